// File: rtl/vga_pkg.sv
// Shared constants for the VGA player datapath: colour and stream byte layout,
// stall counter width, and the RLE decoder state encoding.
package vga_pkg;

    localparam int unsigned RGB_W   = 6;
    localparam int unsigned RGB_LSB = 0;
    localparam int unsigned RPT_LSB = 6;
    localparam int unsigned RPT_W   = 2;
    localparam int unsigned BYTE_W  = RPT_W + RGB_W;
    localparam int unsigned STALL_W = 16;

    // LOAD: next pixel comes from the FIFO head; REPEAT: replaying cur_color
    typedef enum logic {
        DEC_LOAD   = 1'b0,
        DEC_REPEAT = 1'b1
    } dec_state_e;

endpackage

// File: rtl/vga_rle_pixel_feeder_if.sv
// Byte stream handshake into the pixel feeder.
//   in_data  : {repeat[1:0], R1,R0,G1,G0,B1,B0}
//   in_valid : in_data is valid (source -> feeder)
//   in_ready : feeder accepts the byte this cycle (feeder -> source)
interface vga_rle_pixel_feeder_if;

    logic [vga_pkg::BYTE_W-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty derive from level.
//   clk, rst_n   : clock, async active-low reset
//   flush        : synchronous clear (wins over push/pop)
//   push/wr_data : write request, ignored when full
//   pop          : read request, ignored when empty
//   rd_data_c    : current head (combinational from storage)
//   full_c/empty_c/level : occupancy
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [LVL_W-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_c    = (level == LVL_W'(DEPTH));
    assign empty_c   = (level == '0);
    assign do_push   = push & ~full_c & ~flush;
    assign do_pop    = pop & ~empty_c & ~flush;
    assign rd_data_c = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // Storage needs no reset; contents are only visible through level
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/vga_rle_pixel_feeder.sv
// Expands a run-length-encoded RGB222 byte stream into one pixel per active
// video cycle and paces the sync generator through data_done.
//   px_clk, rst_n : pixel clock, async active-low reset
//   flush         : clear buffered stream state (stall_cnt kept)
//   in_if         : byte stream handshake (slave side)
//   activevideo   : sync generator shows a visible position
//   data_done     : advance permission to the sync generator (combinational)
//   rgb           : registered pixel colour
//   fifo_level    : occupied FIFO entries
//   stall_cnt     : saturating count of underrun cycles
module vga_rle_pixel_feeder
    import vga_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned RLE_EN     = 1,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     px_clk,
    input  logic                     rst_n,
    input  logic                     flush,
    vga_rle_pixel_feeder_if.slave    in_if,
    input  logic                     activevideo,
    output logic                     data_done,
    output logic [RGB_W-1:0]         rgb,
    output logic [LVL_W-1:0]         fifo_level,
    output logic [STALL_W-1:0]       stall_cnt
);

    dec_state_e         state_q,     state_d;
    logic [RPT_W-1:0]   run_left_q,  run_left_d;
    logic [RGB_W-1:0]   cur_color_q, cur_color_d;
    logic [RGB_W-1:0]   rgb_q,       rgb_d;
    logic [STALL_W-1:0] stall_q,     stall_d;

    logic [BYTE_W-1:0]  fifo_head_c;
    logic [RGB_W-1:0]   head_rgb_c;
    logic [RPT_W-1:0]   head_rpt_c;
    logic               fifo_full_c;
    logic               fifo_empty_c;
    logic               pop_c;
    logic               push_c;
    logic               pix_avail_c;

    assign head_rgb_c = fifo_head_c[RGB_LSB +: RGB_W];
    assign head_rpt_c = fifo_head_c[RPT_LSB +: RPT_W];

    assign in_if.in_ready = ~fifo_full_c;
    assign push_c         = in_if.in_valid & ~fifo_full_c & ~flush;
    assign pix_avail_c    = (run_left_q != '0) | ~fifo_empty_c;
    // Depends on registered state only, so no loop through the sync generator
    assign data_done      = ~activevideo | pix_avail_c;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (px_clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push_c),
        .wr_data   (in_if.in_data),
        .pop       (pop_c),
        .rd_data_c (fifo_head_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c),
        .level     (fifo_level)
    );

    // Decoder next state, pixel selection and FIFO pop
    always_comb begin
        state_d     = state_q;
        run_left_d  = run_left_q;
        cur_color_d = cur_color_q;
        rgb_d       = rgb_q;
        pop_c       = 1'b0;

        if (flush) begin
            state_d     = DEC_LOAD;
            run_left_d  = '0;
            cur_color_d = '0;
            rgb_d       = '0;
        end else if (!activevideo) begin
            rgb_d = '0;
        end else begin
            unique case (state_q)
                DEC_REPEAT: begin
                    rgb_d      = cur_color_q;
                    run_left_d = run_left_q - RPT_W'(1);
                    state_d    = (run_left_q == RPT_W'(1)) ? DEC_LOAD : DEC_REPEAT;
                end
                DEC_LOAD: begin
                    // Empty FIFO here is an underrun: rgb holds
                    if (!fifo_empty_c) begin
                        pop_c       = 1'b1;
                        rgb_d       = head_rgb_c;
                        cur_color_d = head_rgb_c;
                        run_left_d  = (RLE_EN != 0) ? head_rpt_c : '0;
                        state_d     = (run_left_d != '0) ? DEC_REPEAT : DEC_LOAD;
                    end
                end
                default: state_d = DEC_LOAD;
            endcase
        end
    end

    // Saturating underrun counter
    always_comb begin
        stall_d = stall_q;
        if (activevideo && !pix_avail_c && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DEC_LOAD;
            run_left_q  <= '0;
            cur_color_q <= '0;
            rgb_q       <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            run_left_q  <= run_left_d;
            cur_color_q <= cur_color_d;
            rgb_q       <= rgb_d;
            stall_q     <= stall_d;
        end
    end

    assign rgb       = rgb_q;
    assign stall_cnt = stall_q;

endmodule
